imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Sequencing controller that loads a program into the byte-addressed, big-endian instruction memory of the single-cycle CPU and then releases the CPU to execute it. It accepts 32-bit instruction words over a valid/ready stream, converts them into write strobes at consecutive word addresses, and tracks capacity and stream stalls. It also produces the run/start signals that gate the CPU's PC and fetch. It sits between the test/boot source and the instruction memory write port, alongside the CPU top.

## Interface
Parameters:
- DEPTH_BYTES, 80, instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 32, width of the memory byte address.
- TIMEOUT, 16, maximum idle cycles in LOAD before declaring an error; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- load_req  in  1  level; sampled each cycle; starts or restarts a load.
- in_valid  in  1  stream word valid.
- in_data  in  32  instruction word; byte [31:24] goes to the lowest address.
- in_last  in  1  marks the final word of the program.
- in_ready  out  1  controller accepts a word this cycle.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_waddr  out  ADDR_W  byte address of the word written; always a multiple of 4.
- mem_wdata  out  32  word being written.
- cpu_run  out  1  CPU may fetch and execute; low holds the PC at 0.
- cpu_start  out  1  one-cycle pulse on entry to RUN.
- load_done  out  1  high while in RUN.
- load_err  out  1  high while in ERR.
- word_count  out  ADDR_W  number of words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, RUN, ERR. Reset state is IDLE.
- Output reset values: every output is 0, and mem_waddr/word_count are 0.
- IDLE:
  - in_ready=0.
  - load_req=1 → LOAD, and word_count clears to 0.
- LOAD:
  - in_ready=1.
  - A word is accepted when in_valid & in_ready.
  - Each accepted word k (0-based) is written at byte address 4k, and word_count increments.
  - Exit to RUN after the accepted word has in_last=1, or after word DEPTH_BYTES/4−1 is accepted (memory full). Full with in_last=0 is not an error; later stream words are simply not accepted.
  - Idle counter: counts consecutive LOAD cycles with in_valid=0 and clears on every accept. Reaching TIMEOUT → ERR.
  - load_req in LOAD is ignored.
- RUN:
  - cpu_run=1 and load_done=1; cpu_start=1 in the first RUN cycle only.
  - load_req=1 → LOAD. cpu_run drops in the next cycle and word_count clears.
- ERR:
  - load_err=1, cpu_run=0, in_ready=0.
  - load_req=1 → LOAD, with word_count cleared.
- Simultaneous events:
  - If an accept with in_last occurs in the same cycle the idle counter would reach TIMEOUT, the accept wins → RUN. This cannot actually happen, because an accept clears the counter.
  - A full memory and in_last on the same word → RUN, with a single transition.
- Arithmetic: mem_waddr = word index × 4, computed at ADDR_W bits. The index never exceeds DEPTH_BYTES/4−1, so there is no wrap-around.
- Reset mid-load: the controller returns to IDLE and mem_we drops in the next cycle. Memory contents already written are not cleared.

## Timing
- Write latency: a word accepted at edge N drives mem_we, mem_waddr and mem_wdata from registers during cycle N+1, for exactly one cycle.
- Throughput: one word per cycle.
- in_ready is a Moore output (state only), with no combinational dependence on in_valid.
- RUN is entered at the edge after the final accept. The final mem_we and cpu_start occur in the same cycle, so memory is complete at the edge on which the CPU first fetches.
- LOAD→ERR occurs at the edge on which the idle counter reaches TIMEOUT, i.e. after TIMEOUT full idle cycles.
- All transitions take one edge. The load_req response is visible one cycle after sampling.

## Structure
- Shared package imem_pkg holds:
  - the state enum (IDLE, LOAD, RUN, ERR);
  - WORD_BYTES=4;
  - the default DEPTH_BYTES.
- The CPU top and the instruction memory import the same DEPTH_BYTES.
- One sub-module: imem_idle_timer, a TIMEOUT counter with clear/enable inputs and an expire output. Everything else is inline.

## Test plan
- Load 20 words with in_valid held high and in_last on word 19 → mem_we for 20 consecutive cycles at addresses 0,4,…,76; cpu_start pulses once; word_count=20; load_done=1.
- Full without last: stream 25 words with in_last=0 (DEPTH_BYTES=80) → exactly 20 writes; in_ready=0 after the 20th accept; RUN entered; no load_err.
- Gaps: insert 3 idle cycles between words with TIMEOUT=16 → all words written in order and no error. A gap of 16 cycles → load_err=1, cpu_run=0, in_ready=0.
- Reload: load_req in RUN → cpu_run falls the next cycle; word_count=0; a new 2-word load writes addresses 0 and 4 and pulses cpu_start again.
- Reset mid-load: assert reset after 5 accepts → all outputs 0 at the next edge; IDLE; no further mem_we. load_req from ERR also recovers to LOAD.
- Backpressure ordering: in_data=0x8E080000 as the first word → mem_wdata=0x8E080000 and mem_waddr=0 in the cycle after accept.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load path.
// Holds the controller state encoding, the word size in bytes and the
// default instruction memory depth, which the CPU top and the instruction
// memory import as well so all three agree on capacity.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } ctrl_state_t;

    localparam int WORD_BYTES  = 4;
    localparam int DEPTH_BYTES = 80;

endpackage

// File: rtl/imem_idle_timer.sv
// Idle-cycle counter for the load stream.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : forces the count back to zero (has priority over en)
//   en         : counts one idle cycle
//   expire     : high in the idle cycle that brings the count to TIMEOUT,
//                so the owner can react on that same edge
module imem_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_reg;

    // The count only needs to reach TIMEOUT-1: the next idle cycle is the
    // one that expires, and the owner leaves the counting state on it.
    assign expire = en && (count_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller.
// Accepts 32-bit program words on a valid/ready stream, writes them to
// consecutive word addresses of the instruction memory, then releases the
// CPU to run. A stalled stream (TIMEOUT idle cycles) lands in ERR.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   load_req                   : start / restart a load (ignored in LOAD)
//   in_valid, in_data, in_last : program word stream, in_ready back
//   mem_we, mem_waddr, mem_wdata : registered memory write port
//   cpu_run, cpu_start         : CPU enable and one-cycle start pulse
//   load_done, load_err        : status (RUN / ERR)
//   word_count                 : words accepted in the current/last load
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = imem_pkg::DEPTH_BYTES,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              cpu_start,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] word_count
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / WORD_BYTES;

    ctrl_state_t       state_reg, state_next;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_waddr_reg;
    logic [31:0]       mem_wdata_reg;
    logic [ADDR_W-1:0] word_count_reg;
    logic              start_reg;

    logic accept;
    logic last_slot;
    logic timer_clr;
    logic timer_en;
    logic timer_expire;

    // Moore handshake: ready depends on state only.
    assign in_ready  = (state_reg == LOAD);
    assign accept    = in_ready && in_valid;
    // word_count is the index of the word being accepted right now.
    assign last_slot = (word_count_reg == ADDR_W'(DEPTH_WORDS - 1));

    // Any accept (or being outside LOAD) restarts the idle count, so a
    // final accept can never coincide with an expiry.
    assign timer_clr = !in_ready || accept;
    assign timer_en  = in_ready && !in_valid;

    imem_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (load_req) state_next = LOAD;
            LOAD: begin
                if (accept && (in_last || last_slot)) begin
                    state_next = RUN;
                end else if (timer_expire) begin
                    state_next = ERR;
                end
            end
            RUN:  if (load_req) state_next = LOAD;
            ERR:  if (load_req) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mem_we_reg     <= 1'b0;
            mem_waddr_reg  <= '0;
            mem_wdata_reg  <= '0;
            word_count_reg <= '0;
            start_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= accept;
            start_reg  <= (state_next == RUN) && (state_reg != RUN);
            if (accept) begin
                // Byte address = word index * 4 at full address width.
                mem_waddr_reg  <= {word_count_reg[ADDR_W-3:0], 2'b00};
                mem_wdata_reg  <= in_data;
                word_count_reg <= word_count_reg + 1'b1;
            end else if ((state_reg != LOAD) && (state_next == LOAD)) begin
                word_count_reg <= '0;
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_waddr  = mem_waddr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = word_count_reg;
    assign cpu_start  = start_reg;
    assign cpu_run    = (state_reg == RUN);
    assign load_done  = (state_reg == RUN);
    assign load_err   = (state_reg == ERR);

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: randomized program loads with a
// scoreboard of expected memory writes and a behavioural controller model.
module tb_imem_load_ctrl;

    localparam int DEPTH = 80;
    localparam int AW    = 32;
    localparam int TO    = 16;
    localparam int NW    = DEPTH / 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_req;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          cpu_start;
    logic          load_done;
    logic          load_err;
    logic [AW-1:0] word_count;

    imem_load_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (AW),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .cpu_start  (cpu_start),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Behavioural model: which phase the loader is in and how far it got.
    bit m_load, m_run, m_err, m_pulse;
    int m_count, m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write the DUT presents must be the next
    // expected (address, data) pair.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_waddr, mem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("mem_waddr", mem_waddr, w.addr);
                chk("mem_wdata", mem_wdata, w.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_flags();
        chk("in_ready",   32'(in_ready),  32'(m_load));
        chk("cpu_run",    32'(cpu_run),   32'(m_run));
        chk("load_done",  32'(load_done), 32'(m_run));
        chk("load_err",   32'(load_err),  32'(m_err));
        chk("cpu_start",  32'(cpu_start), 32'(m_pulse));
        chk("word_count", word_count,     32'(m_count));
    endtask

    // One stream cycle; called on a negative edge, returns on the next one.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit lr);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        load_req = lr;
        m_pulse  = 0;
        chk("in_ready_pre", 32'(in_ready), 32'(m_load));
        if (m_load) begin
            if (v) begin
                exp_q.push_back('{addr: 32'(m_count * 4), data: d});
                m_count++;
                m_idle = 0;
                if (l || m_count == NW) begin
                    m_load  = 0;
                    m_run   = 1;
                    m_pulse = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_load = 0;
                    m_err  = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
        load_req = 0;
        check_flags();
    endtask

    task automatic req_load();
        load_req = 1;
        m_pulse  = 0;
        if (!m_load) begin
            m_load  = 1;
            m_run   = 0;
            m_err   = 0;
            m_count = 0;
            m_idle  = 0;
        end
        @(posedge clk);
        @(negedge clk);
        load_req = 0;
        check_flags();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0);
    endtask

    task automatic drained();
        idle(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset    = 1;
        load_req = 0;
        in_valid = 0;
        in_data  = 0;
        in_last  = 0;
        m_load = 0; m_run = 0; m_err = 0; m_pulse = 0;
        m_count = 0; m_idle = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check_flags();
        chk("rst_mem_we",    32'(mem_we), 32'd0);
        chk("rst_mem_waddr", mem_waddr,   32'd0);
        chk("rst_mem_wdata", mem_wdata,   32'd0);

        // 20-word program, back-to-back, last on word 19.
        req_load();
        for (int k = 0; k < NW; k++) step(1, $urandom, (k == NW - 1), 0);
        idle(1);   // cpu_start must have been a single pulse
        drained();

        // Reload from RUN with a 2-word program.
        req_load();
        step(1, 32'h8E08_0000, 0, 0);
        step(1, $urandom, 1, 0);
        drained();

        // Memory fills before the stream ends: extra words not accepted.
        req_load();
        for (int k = 0; k < 25; k++) step(1, $urandom, 0, 0);
        drained();

        // Random programs with idle gaps below the timeout; load_req
        // pulses during LOAD must be ignored.
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, NW);
            req_load();
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = (it == 3) ? $urandom_range(0, TO - 1) : $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) step(0, 32'h0, 0, ($urandom_range(0, 7) == 0));
                step(1, $urandom, (k == n - 1), 0);
            end
            drained();
        end

        // Stall: TO idle cycles after two words lands in ERR.
        req_load();
        step(1, $urandom, 0, 0);
        step(1, $urandom, 0, 0);
        idle(TO);
        idle(2);
        chk("queue_drained_err", 32'(exp_q.size()), 32'd0);

        // Recover from ERR, then reset after 5 accepts.
        req_load();
        for (int k = 0; k < 5; k++) step(1, $urandom, 0, 0);
        reset    = 1;
        in_valid = 1;
        in_data  = $urandom;
        @(posedge clk);
        @(negedge clk);
        reset    = 0;
        in_valid = 0;
        m_load = 0; m_run = 0; m_err = 0; m_pulse = 0;
        m_count = 0; m_idle = 0;
        check_flags();
        chk("midrst_mem_we",    32'(mem_we), 32'd0);
        chk("midrst_mem_waddr", mem_waddr,   32'd0);
        chk("midrst_mem_wdata", mem_wdata,   32'd0);
        idle(3);
        chk("queue_drained_rst", 32'(exp_q.size()), 32'd0);

        // Load again from IDLE after the reset.
        req_load();
        for (int k = 0; k < 3; k++) step(1, $urandom, (k == 2), 0);
        drained();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
